// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder
//
// Adds two WIDTH-bit operands one nibble per clock through a single 4-bit
// carry-lookahead core. The ripple carry between nibbles is registered.
// Operands are accepted with a valid/ready handshake. The result is returned
// with a second valid/ready handshake.
//
// Optional feature: define SUB_MODE_EN to add the in_sub port, which selects
// subtraction (a - b = a + ~b + 1).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands / carry-in valid
//   in_ready   operands accepted (high only when idle)
//   in_a       operand A
//   in_b       operand B
//   in_cin     carry-in to nibble 0
//   out_valid  result valid (high only when done)
//   out_ready  consumer accepts result
//   in_sub     (SUB_MODE_EN only) 1 = subtract in_b from in_a
//   out_sum    registered WIDTH-bit sum
//   out_cout   registered carry-out of the top nibble
//   busy       operation in progress or result pending
module cla_nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SUB_MODE_EN
    input  logic             in_sub,
`endif
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [IW-1:0]     idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;

    logic              sub_sel;
    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [4:0]        nib_res;

`ifdef SUB_MODE_EN
    assign sub_sel = in_sub;
`else
    assign sub_sel = 1'b0;
`endif

    // 4-bit carry-lookahead core: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    always_comb begin
        nib_a   = a_q[{idx_q, 2'b00} +: 4];
        nib_b   = b_q[{idx_q, 2'b00} +: 4];
        nib_res = cla4(nib_a, nib_b, carry_q);
    end

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= sub_sel ? ~in_b : in_b;
                        carry_q <= sub_sel ? 1'b1 : in_cin;
                        idx_q   <= '0;
                        out_sum <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    out_sum[{idx_q, 2'b00} +: 4] <= nib_res[3:0];
                    carry_q                      <= nib_res[4];
                    if (idx_q == LastIdx) begin
                        // Park the index at 0 so it never exceeds NIB-1.
                        idx_q    <= '0;
                        out_cout <= nib_res[4];
                        state_q  <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed self-checking bench for cla_nibble_serial_adder (WIDTH=16).
module tb_cla_nibble_serial_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;
`ifdef SUB_MODE_EN
    logic             in_sub;
`endif

    int n_cmp;
    int n_err;

    cla_nibble_serial_adder #(
        .WIDTH(WIDTH)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef SUB_MODE_EN
        .in_sub   (in_sub),
`endif
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one operation and follow it to DONE, checking the latency on the way.
    // Returns at the falling edge after the NIB-th RUN edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub);
        @(negedge clk);
        check("accept_ready", in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
`ifdef SUB_MODE_EN
        in_sub   = sub;
`else
        if (sub) $display("note: subtraction requested without SUB_MODE_EN");
`endif
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Operands must have been captured; scramble the inputs.
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
        in_cin   = 1'b1;
        for (int k = 0; k < NIB; k++) begin
            check("run_valid_low", out_valid, 0);
            check("run_ready_low", in_ready, 0);
            check("run_busy", busy, 1);
            @(negedge clk);
        end
    endtask

    task automatic finish_op(input string tag, input logic [WIDTH-1:0] exp_sum,
                             input logic exp_cout);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_ready_low"}, in_ready, 0);
        check({tag, "_sum"}, out_sum, exp_sum);
        check({tag, "_cout"}, out_cout, exp_cout);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
        out_ready = 1'b0;
    endtask

    logic [WIDTH-1:0] b2b_a   [3];
    logic [WIDTH-1:0] b2b_b   [3];
    logic             b2b_c   [3];
    logic [WIDTH-1:0] b2b_s   [3];
    logic             b2b_co  [3];
    int               acc_cyc [3];
    logic [WIDTH-1:0] res_s   [3];
    logic             res_co  [3];
    int               nacc;
    int               nres;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
`ifdef SUB_MODE_EN
        in_sub    = 1'b0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", out_sum, 0);
        check("rst_cout", out_cout, 0);
        rst_n = 1'b1;

        // Full-width wrap: FFFF + 0001 -> 0000, carry out
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        finish_op("wrap", 16'h0000, 1'b1);

        // Carry-in used: 1234 + 4321 + 1 -> 5556
        start_op(16'h1234, 16'h4321, 1'b1, 1'b0);
        finish_op("cin", 16'h5556, 1'b0);

        // Carry ripples through every nibble boundary
        start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        finish_op("ripple", 16'h1000, 1'b0);

        // Backpressure: DONE held 10 cycles, in_valid pulses are ignored
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", out_valid, 1);
            check("bp_sum", out_sum, 16'h8000);
            check("bp_ready_low", in_ready, 0);
            in_valid = (c >= 3 && c <= 5);
            in_a     = 16'h1111;
            in_b     = 16'h2222;
            @(negedge clk);
        end
        in_valid = 1'b0;
        finish_op("bp", 16'h8000, 1'b0);

        // Reset after the 2nd RUN edge discards the partial result
        @(negedge clk);
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sum", out_sum, 0);
        check("mid_rst_cout", out_cout, 0);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        finish_op("post_rst", 16'h0100, 1'b0);

        // Back-to-back with in_valid and out_ready tied high
        b2b_a[0] = 16'h0F0F; b2b_b[0] = 16'h00F1; b2b_c[0] = 1'b0;
        b2b_s[0] = 16'h1000; b2b_co[0] = 1'b0;
        b2b_a[1] = 16'hFFFF; b2b_b[1] = 16'hFFFF; b2b_c[1] = 1'b1;
        b2b_s[1] = 16'hFFFF; b2b_co[1] = 1'b1;
        b2b_a[2] = 16'h1111; b2b_b[2] = 16'h2222; b2b_c[2] = 1'b0;
        b2b_s[2] = 16'h3333; b2b_co[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            acc_cyc[i] = -100;
            res_s[i]   = '0;
            res_co[i]  = 1'b0;
        end
        nacc = 0;
        nres = 0;
        @(negedge clk);
        in_a      = b2b_a[0];
        in_b      = b2b_b[0];
        in_cin    = b2b_c[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (out_valid && nres < 3) begin
                res_s[nres]  = out_sum;
                res_co[nres] = out_cout;
                nres++;
            end
            if (in_ready && in_valid && nacc < 3) begin
                acc_cyc[nacc] = c;
                nacc++;
            end else if (nacc < 3) begin
                in_a   = b2b_a[nacc];
                in_b   = b2b_b[nacc];
                in_cin = b2b_c[nacc];
            end else if (!in_ready) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_accepts", nacc, 3);
        check("b2b_results", nres, 3);
        check("b2b_gap01", acc_cyc[1] - acc_cyc[0], NIB + 2);
        check("b2b_gap12", acc_cyc[2] - acc_cyc[1], NIB + 2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b_sum%0d", i), res_s[i], b2b_s[i]);
            check($sformatf("b2b_cout%0d", i), res_co[i], b2b_co[i]);
        end

`ifdef SUB_MODE_EN
        // 5 - 7 -> FFFE with borrow; 7 - 5 -> 0002 without borrow
        start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        finish_op("sub_neg", 16'hFFFE, 1'b0);
        start_op(16'h0007, 16'h0005, 1'b0, 1'b1);
        finish_op("sub_pos", 16'h0002, 1'b1);
        in_sub = 1'b0;
        start_op(16'h0007, 16'h0005, 1'b0, 1'b0);
        finish_op("sub_off", 16'h000C, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cla_nibble_serial_adder.md
Name: cla_nibble_serial_adder

Overview:
Wide-operand adder front end that feeds the team's 4-bit carry-lookahead adder one nibble per clock and consumes its sum and carry-out. It latches two WIDTH-bit operands through a valid/ready handshake and sequences the nibbles LSB first. It registers the ripple carry between nibbles and presents the full WIDTH-bit result and final carry through a second valid/ready handshake. It trades throughput for area, so wide adds can reuse one 4-bit CLA core.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NIB, WIDTH/4, derived local parameter: number of nibble steps per operation (not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/carry-in valid
in_ready  output  1  block can accept operands (high only in IDLE)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in to nibble 0
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  registered sum
out_cout  output  1  registered carry-out of the top nibble
busy  output  1  high in RUN or DONE

Behaviour:
- Clocking: one clock (clk). Reset: asynchronous, active-low (rst_n); polarity and synchronicity are fixed.
- Reset (rst_n low, any time, including mid-RUN): state=IDLE, nibble index=0, carry reg=0, operand regs=0, out_sum=0, out_cout=0, out_valid=0, busy=0. in_ready=1 once state is IDLE. Any in-flight operation is discarded; no partial result is ever presented.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at a rising edge: latch in_a, in_b; carry reg<=in_cin; index<=0; out_sum<=0; go to RUN.
  - RUN: each edge, the CLA core adds A[4i+3:4i], B[4i+3:4i] and the carry reg. The sum nibble is written to out_sum[4i+3:4i], carry reg<=CLA carry-out, index<=index+1. On the edge where index==NIB-1: out_cout<=CLA carry-out and go to DONE. in_valid is ignored.
  - DONE: out_valid=1 and out_sum/out_cout are held stable. On out_ready go to IDLE; out_valid drops the next cycle. If out_ready stays low, the block holds indefinitely.
- Latency: out_valid rises exactly NIB edges after the accept edge. Minimum issue interval is NIB+2 cycles (accept, NIB RUN edges, DONE with out_ready=1, IDLE).
- in_ready and out_valid are never high in the same cycle. in_ready is a pure decode of state, with no combinational path from in_valid or out_ready.
- Result arithmetic: {out_cout,out_sum} == in_a + in_b + in_cin, computed as unsigned (WIDTH+1)-bit. Wrap-around is expressed only through out_cout.
- Index counter is $clog2(NIB) bits (minimum 1). It never exceeds NIB-1 and clears on entry to RUN.
- Operand registers are not updated while busy, so in_a/in_b may change freely after the accept edge.
- WIDTH==4: NIB=1, one RUN edge, and the block acts as a registered 4-bit CLA with handshake.

Optional Feature:
SUB_MODE_EN. When defined, the block adds input port in_sub (1 bit), sampled at the accept edge. When in_sub=1, the block latches ~in_b and forces the carry reg to 1, ignoring in_cin. The result is in_a - in_b modulo 2^WIDTH, and out_cout=1 means no borrow. When SUB_MODE_EN is undefined, the in_sub port does not exist and the block performs addition only.

Test Plan:
- WIDTH=16: in_a=0xFFFF, in_b=0x0001, in_cin=0 -> out_sum=0x0000, out_cout=1, out_valid rises 4 edges after accept.
- in_a=0x1234, in_b=0x4321, in_cin=1 -> out_sum=0x5556, out_cout=0. in_ready is low from the accept edge until out_ready is seen in DONE.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1 and out_sum is stable. Pulse in_valid with new operands meanwhile -> ignored (in_ready=0).
- Reset mid-RUN: assert rst_n=0 after the 2nd RUN edge -> out_valid=0, out_sum=0, in_ready=1 after release. The next op 0x00FF+0x0001 yields 0x0100.
- Back-to-back: out_ready tied 1, in_valid tied 1, 3 ops -> accepts spaced exactly NIB+2=6 cycles apart, results in order.
- SUB_MODE_EN: in_a=0x0005, in_b=0x0007, in_sub=1 -> out_sum=0xFFFE, out_cout=0. 0x0007-0x0005 -> 0x0002, out_cout=1.
